uart_rx: RTL and testbench

8N1 UART receiver; the receive-side counterpart to the team's UART transmitter.
- Samples the asynchronous serial line with an oversampling baud_clk.
- Validates the start bit at mid-bit and shifts in 8 data bits LSB first.
- Checks the stop bit, then presents the byte with a one-cycle valid pulse, or flags a framing error.
- Sits between the board RX pin and the byte-consuming logic (loopback/echo, command parsers).

---
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start-bit qualification, LSB-first data, stop-bit check.
// Byte (valid) or framing error (frame_err) is pulsed one cycle after the stop-bit sample.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF  = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       dout_nxt;
  logic             valid_nxt, ferr_nxt;
  logic             sync1, rx_s;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      dout      <= dout_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    dout_nxt  = dout;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    if (state != IDLE && !rx_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rx_en && !rx_s) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            if (!rx_s) begin
              state_nxt = DATA;
              cnt_nxt   = '0;
              idx_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            shreg_nxt = {rx_s, shreg[7:1]};
            cnt_nxt   = '0;
            if (idx == 3'd7) state_nxt = STOP;
            else             idx_nxt   = idx + 3'd1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_nxt = '0;
            if (rx_s) begin
              dout_nxt  = shreg;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = BRK;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        // Line held low after a bad stop bit: wait for it to return high before re-arming.
        BRK: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected events stamped with the cycle they must appear.
module tb_uart_rx;

  logic       baud_clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       rxd;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .baud_clk (baud_clk),
    .rst      (rst),
    .rx_en    (rx_en),
    .rxd      (rxd),
    .dout     (dout),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard queue.
  always @(negedge baud_clk) begin
    if (valid || frame_err) begin
      check("not_both", {31'd0, valid & frame_err}, 32'd0);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: valid=%0b frame_err=%0b dout=%0h at cycle %0d, expected none",
                 valid, frame_err, dout, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("event_kind", {31'd0, frame_err}, {31'd0, e.ferr});
        check("event_cycle", cyc, e.cyc);
        if (!e.ferr) check("dout", {24'd0, dout}, {24'd0, e.data});
      end
    end
  end

  // Drives the first ncyc cycles of an 8N1 frame (16 cycles per bit); called on a negedge.
  task automatic send(input logic [7:0] b, input logic stop, input bit expect_out, input int ncyc);
    logic [9:0] frame;
    ev_t e;
    frame = {stop, b, 1'b0};
    if (expect_out) begin
      e.ferr = !stop;
      e.data = b;
      e.cyc  = cyc + 155;
      q.push_back(e);
    end
    for (int i = 0; i < ncyc; i++) begin
      rxd = frame[i/16];
      @(negedge baud_clk);
    end
  endtask

  initial begin
    int c0;
    rst   = 1'b1;
    rx_en = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge baud_clk);
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge baud_clk);

    // Single frame
    send(8'hA5, 1'b1, 1'b1, 160);
    repeat (20) @(negedge baud_clk);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back frames, no idle gap
    send(8'h00, 1'b1, 1'b1, 160);
    send(8'hFF, 1'b1, 1'b1, 160);
    repeat (20) @(negedge baud_clk);

    // Short low glitch: rejected at the mid-start check
    c0  = cyc;
    rxd = 1'b0;
    repeat (4) @(negedge baud_clk);
    rxd = 1'b1;
    check("glitch_busy_early", {31'd0, busy}, 32'd1);
    repeat (6) @(negedge baud_clk);
    check("glitch_busy_c10", {31'd0, busy}, 32'd1);
    @(negedge baud_clk);
    check("glitch_cycle", cyc - c0, 32'd11);
    check("glitch_busy_c11", {31'd0, busy}, 32'd0);
    check("glitch_dout", {24'd0, dout}, 32'hFF);
    repeat (20) @(negedge baud_clk);

    // Framing error followed by a long break, then a good frame
    send(8'h3C, 1'b0, 1'b1, 160);
    repeat (640) @(negedge baud_clk);
    check("brk_busy", {31'd0, busy}, 32'd1);
    check("brk_dout_kept", {24'd0, dout}, 32'hFF);
    rxd = 1'b1;
    repeat (32) @(negedge baud_clk);
    check("brk_released", {31'd0, busy}, 32'd0);
    send(8'h55, 1'b1, 1'b1, 160);
    repeat (20) @(negedge baud_clk);

    // Reset in the middle of data bit 4
    send(8'h81, 1'b1, 1'b0, 88);
    rst = 1'b1;
    #1;
    check("midrst_dout", {24'd0, dout}, 32'h00);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    @(negedge baud_clk);
    rxd = 1'b1;
    repeat (3) @(negedge baud_clk);
    rst = 1'b0;
    repeat (10) @(negedge baud_clk);
    send(8'h42, 1'b1, 1'b1, 160);
    repeat (20) @(negedge baud_clk);

    // Receiver disabled: line activity ignored
    rx_en = 1'b0;
    send(8'h99, 1'b1, 1'b0, 40);
    check("dis_busy_mid", {31'd0, busy}, 32'd0);
    rxd = 1'b1;
    repeat (160) @(negedge baud_clk);
    check("dis_busy_end", {31'd0, busy}, 32'd0);
    check("dis_dout", {24'd0, dout}, 32'h42);

    // Disable mid-frame: abort without output
    rx_en = 1'b1;
    repeat (5) @(negedge baud_clk);
    send(8'h77, 1'b1, 1'b0, 80);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rx_en = 1'b0;
    @(negedge baud_clk);
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    rxd = 1'b1;
    repeat (40) @(negedge baud_clk);
    rx_en = 1'b1;
    repeat (200) @(negedge baud_clk);
    check("abort_dout", {24'd0, dout}, 32'h42);

    // Recovery after abort
    send(8'h5A, 1'b1, 1'b1, 160);
    repeat (20) @(negedge baud_clk);
    check("queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
